// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with flush/stall control, HI/LO and load/store sideband, MADD/MSUB carry-back, bubble counter.
// Latency: 1 cycle EX->MEM; every output comes straight from a flop, so there is no input->output combinational path.
// Backpressure: stall_ex alone inserts a bubble; stall_ex with stall_mem holds every register; flush clears and overrides both stalls.
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_ex,
    input  logic                    stall_mem,
    input  logic                    flush,
    input  logic                    ex_valid,
    input  logic [REG_ADDR_W-1:0]   ex_wd,
    input  logic                    ex_wreg,
    input  logic [DATA_W-1:0]       ex_wdata,
    input  logic                    ex_whilo,
    input  logic [DATA_W-1:0]       ex_hi,
    input  logic [DATA_W-1:0]       ex_lo,
    input  logic [ALUOP_W-1:0]      ex_aluop,
    input  logic [DATA_W-1:0]       ex_mem_addr,
    input  logic [DATA_W-1:0]       ex_reg2,
    input  logic [2*DATA_W-1:0]     hilo_temp_i,
    input  logic [1:0]              cnt_i,
    output logic                    mem_valid,
    output logic [REG_ADDR_W-1:0]   mem_wd,
    output logic                    mem_wreg,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    mem_whilo,
    output logic [DATA_W-1:0]       mem_hi,
    output logic [DATA_W-1:0]       mem_lo,
    output logic [ALUOP_W-1:0]      mem_aluop,
    output logic [DATA_W-1:0]       mem_mem_addr,
    output logic [DATA_W-1:0]       mem_reg2,
    output logic [2*DATA_W-1:0]     hilo_temp_o,
    output logic [1:0]              cnt_o,
    output logic [CNT_W-1:0]        bubble_cnt
);

    // Everything that travels forward into MEM, kept as one record so the
    // clear/capture/hold decisions act on the whole instruction at once.
    typedef struct packed {
        logic                   valid;
        logic [REG_ADDR_W-1:0]  wd;
        logic                   wreg;
        logic [DATA_W-1:0]      wdata;
        logic                   whilo;
        logic [DATA_W-1:0]      hi;
        logic [DATA_W-1:0]      lo;
        logic [ALUOP_W-1:0]     aluop;
        logic [DATA_W-1:0]      mem_addr;
        logic [DATA_W-1:0]      reg2;
    } stage_t;

    // Multi-cycle MADD/MSUB progress that is looped back to EX.
    typedef struct packed {
        logic [2*DATA_W-1:0]    hilo_temp;
        logic [1:0]             cnt;
    } acc_t;

    // What the register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } act_t;

    localparam logic [CNT_W-1:0] BUB_MAX = '1;
    localparam logic [CNT_W-1:0] BUB_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    act_t   act;
    stage_t ex_pkt;
    stage_t stage_q;
    acc_t   acc_q;
    logic [CNT_W-1:0] bubble_q;

    // Pick the edge action. Flush beats any stall; with stall_ex low the
    // stage advances even if stall_mem is (illegally) high, so hold is only
    // reached when both stalls are asserted.
    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall_ex && !stall_mem) begin
            act = ACT_BUBBLE;
        end else if (!stall_ex) begin
            act = ACT_ADVANCE;
        end
    end

    // Assemble the incoming instruction. An invalid slot must never write a
    // register, so its enables and destination are zeroed; data fields are
    // still taken as-is since nothing downstream consumes them without an enable.
    always_comb begin
        ex_pkt          = '0;
        ex_pkt.valid    = ex_valid;
        ex_pkt.wd       = ex_valid ? ex_wd : '0;
        ex_pkt.wreg     = ex_valid & ex_wreg;
        ex_pkt.wdata    = ex_wdata;
        ex_pkt.whilo    = ex_valid & ex_whilo;
        ex_pkt.hi       = ex_hi;
        ex_pkt.lo       = ex_lo;
        ex_pkt.aluop    = ex_aluop;
        ex_pkt.mem_addr = ex_mem_addr;
        ex_pkt.reg2     = ex_reg2;
    end

    // Forward instruction register: cleared on flush or bubble, loaded on advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: stage_q <= '0;
                ACT_ADVANCE:           stage_q <= ex_pkt;
                default:               stage_q <= stage_q;
            endcase
        end
    end

    // Accumulator loop-back: a bubble is exactly when EX is iterating a
    // MADD/MSUB, so its partial product and step index are parked here and
    // fed back; any advance or flush ends the sequence and clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            case (act)
                ACT_FLUSH, ACT_ADVANCE: acc_q <= '0;
                ACT_BUBBLE:             acc_q <= '{hilo_temp: hilo_temp_i, cnt: cnt_i};
                default:                acc_q <= acc_q;
            endcase
        end
    end

    // Count inserted bubbles, sticking at all-ones; flush does not count as a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
        end else if (act == ACT_BUBBLE && bubble_q != BUB_MAX) begin
            bubble_q <= bubble_q + BUB_ONE;
        end
    end

    assign mem_valid    = stage_q.valid;
    assign mem_wd       = stage_q.wd;
    assign mem_wreg     = stage_q.wreg;
    assign mem_wdata    = stage_q.wdata;
    assign mem_whilo    = stage_q.whilo;
    assign mem_hi       = stage_q.hi;
    assign mem_lo       = stage_q.lo;
    assign mem_aluop    = stage_q.aluop;
    assign mem_mem_addr = stage_q.mem_addr;
    assign mem_reg2     = stage_q.reg2;
    assign hilo_temp_o  = acc_q.hilo_temp;
    assign cnt_o        = acc_q.cnt;
    assign bubble_cnt   = bubble_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboarded bench for ex_mem_stage: directed scenarios followed by random traffic.
// Expected outputs are predicted one edge ahead and checked by an independent negedge monitor.
// A narrow bubble counter is used so saturation is reached quickly.
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 8;
    localparam int CW = 2;

    logic clk;
    logic rst;
    logic stall_ex, stall_mem, flush, ex_valid, ex_wreg, ex_whilo;
    logic [AW-1:0]   ex_wd;
    logic [DW-1:0]   ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [OW-1:0]   ex_aluop;
    logic [2*DW-1:0] hilo_temp_i;
    logic [1:0]      cnt_i;
    logic            mem_valid, mem_wreg, mem_whilo;
    logic [AW-1:0]   mem_wd;
    logic [DW-1:0]   mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [OW-1:0]   mem_aluop;
    logic [2*DW-1:0] hilo_temp_o;
    logic [1:0]      cnt_o;
    logic [CW-1:0]   bubble_cnt;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   wd;
        logic            wreg;
        logic [DW-1:0]   wdata;
        logic            whilo;
        logic [DW-1:0]   hi;
        logic [DW-1:0]   lo;
        logic [OW-1:0]   aluop;
        logic [DW-1:0]   addr;
        logic [DW-1:0]   reg2;
        logic [2*DW-1:0] hilo;
        logic [1:0]      cnt;
        logic [CW-1:0]   bub;
    } out_t;

    typedef struct packed {
        logic            flush;
        logic            stall_ex;
        logic            stall_mem;
        logic            valid;
        logic [AW-1:0]   wd;
        logic            wreg;
        logic [DW-1:0]   wdata;
        logic            whilo;
        logic [DW-1:0]   hi;
        logic [DW-1:0]   lo;
        logic [OW-1:0]   aluop;
        logic [DW-1:0]   addr;
        logic [DW-1:0]   reg2;
        logic [2*DW-1:0] hilo;
        logic [1:0]      cnt;
    } in_t;

    typedef struct {
        int    tag;
        out_t  exp;
        string name;
    } exp_t;

    exp_t sb[$];
    out_t mdl;
    out_t act_o;
    int   cyc;
    int   n_checks;
    int   n_pass;

    ex_mem_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_temp_o(hilo_temp_o),
        .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    assign act_o = {mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                    mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o, bubble_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input out_t got, input out_t want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, want);
    endtask

    // Reference behaviour of one clock edge, stated from the stage rules.
    task automatic model(input in_t s);
        if (s.flush) begin
            mdl = '{bub: mdl.bub, default: '0};
        end else if (s.stall_ex && !s.stall_mem) begin
            mdl = '{bub: mdl.bub, default: '0};
            mdl.hilo = s.hilo;
            mdl.cnt  = s.cnt;
            if (int'(mdl.bub) < (1 << CW) - 1) mdl.bub = mdl.bub + 1'b1;
        end else if (!s.stall_ex) begin
            mdl.valid = s.valid;
            mdl.wd    = s.valid ? s.wd : '0;
            mdl.wreg  = s.valid && s.wreg;
            mdl.whilo = s.valid && s.whilo;
            mdl.wdata = s.wdata;
            mdl.hi    = s.hi;
            mdl.lo    = s.lo;
            mdl.aluop = s.aluop;
            mdl.addr  = s.addr;
            mdl.reg2  = s.reg2;
            mdl.hilo  = '0;
            mdl.cnt   = '0;
        end
    endtask

    task automatic drive(input in_t s);
        flush = s.flush;  stall_ex = s.stall_ex;  stall_mem = s.stall_mem;
        ex_valid = s.valid;  ex_wd = s.wd;  ex_wreg = s.wreg;  ex_wdata = s.wdata;
        ex_whilo = s.whilo;  ex_hi = s.hi;  ex_lo = s.lo;  ex_aluop = s.aluop;
        ex_mem_addr = s.addr;  ex_reg2 = s.reg2;  hilo_temp_i = s.hilo;  cnt_i = s.cnt;
    endtask

    function automatic in_t rnd_payload();
        in_t s;
        s       = '0;
        s.valid = 1'($urandom_range(0, 3) != 0);
        s.wd    = AW'($urandom);
        s.wreg  = 1'($urandom);
        s.wdata = $urandom;
        s.whilo = 1'($urandom);
        s.hi    = $urandom;
        s.lo    = $urandom;
        s.aluop = OW'($urandom);
        s.addr  = $urandom;
        s.reg2  = $urandom;
        s.hilo  = {$urandom, $urandom};
        s.cnt   = 2'($urandom);
        return s;
    endfunction

    // Apply one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input in_t s, input string nm);
        exp_t e;
        drive(s);
        model(s);
        e.tag  = cyc + 1;
        e.exp  = mdl;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the stage presents a new result every edge; compare it mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, act_o, e.exp);
        end
    end

    initial begin
        in_t s;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        mdl      = '0;
        rst      = 1'b0;
        drive('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // T2: plain advance of a valid instruction
        s = rnd_payload();
        s.valid = 1'b1; s.wd = 5'd5; s.wreg = 1'b1; s.wdata = 32'hDEADBEEF;
        step(s, "T2_advance");

        // T1: async reset mid-cycle clears everything before the next edge
        @(negedge clk);
        #1;
        s = '0;
        s.stall_ex = 1'b1; s.stall_mem = 1'b1;
        drive(s);
        rst = 1'b0;
        #1;
        mdl = '0;
        chk("T1_async_reset", act_o, mdl);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // T3: bubble carries the accumulator back and counts
        s = rnd_payload();
        s.stall_ex = 1'b1; s.valid = 1'b1; s.wreg = 1'b1;
        s.hilo = 64'h1_0000_0002; s.cnt = 2'd1;
        step(s, "T3_bubble");

        // T4: hold with changing EX inputs
        for (int i = 0; i < 3; i++) begin
            s = rnd_payload();
            s.stall_ex = 1'b1; s.stall_mem = 1'b1;
            step(s, "T4_hold");
        end

        // T5: flush wins over stall, bubble count untouched
        s = rnd_payload();
        s.flush = 1'b1; s.stall_ex = 1'b1;
        step(s, "T5_flush_prio");

        // T6: counter saturation then gating of an invalid advance
        for (int i = 0; i < 5; i++) begin
            s = rnd_payload();
            s.stall_ex = 1'b1;
            step(s, "T6_saturate");
        end
        s = rnd_payload();
        s.valid = 1'b0; s.wreg = 1'b1; s.whilo = 1'b1; s.wd = 5'd7;
        step(s, "T6_gating");

        // Random traffic; stall_ex=0 with stall_mem=1 is never issued by control
        for (int i = 0; i < 1500; i++) begin
            s = rnd_payload();
            s.flush     = 1'($urandom_range(0, 15) == 0);
            s.stall_ex  = 1'($urandom_range(0, 2) == 0);
            s.stall_mem = s.stall_ex ? 1'($urandom) : 1'b0;
            step(s, "random");
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected results left, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
